// File: rtl/rf_writeback_stage.sv
// Register-file writeback stage: selects ALU/load/PC+4/immediate data, waits for load data, issues one write per cycle.
// Optional forwarding port enabled by defining WB_BYPASS_EN; otherwise byp_* are tied to 0.
module rf_writeback_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] rd_addr,
   input  logic [1:0]        wr_src,
   input  logic [XLEN-1:0]   alu_res,
   input  logic [XLEN-1:0]   pc_plus4,
   input  logic [XLEN-1:0]   imm,
   input  logic [2:0]        ld_funct3,
   input  logic [1:0]        ld_off,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_rvalid,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic              byp_valid,
   output logic [REG_AW-1:0] byp_addr,
   output logic [XLEN-1:0]   byp_data
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_MEM = 2'b01,
      WRITE    = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic                rf_we_q, rf_we_d;
   logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]     rf_wdata_q, rf_wdata_d;
   logic [REG_AW-1:0]   pend_addr_q, pend_addr_d;
   logic [2:0]          pend_f3_q, pend_f3_d;
   logic [1:0]          pend_off_q, pend_off_d;

   logic                accept_s;
   logic                cap_en_s;
   logic [REG_AW-1:0]   cap_addr_s;
   logic [XLEN-1:0]     cap_data_s;
   logic [XLEN-1:0]     src_data_s;

   function automatic logic [XLEN-1:0] ld_extend(input logic [31:0] w,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
      logic [7:0]      b;
      logic [15:0]     h;
      logic [XLEN-1:0] r;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      r = {XLEN{1'b0}};
      case (f3)
         3'b000: begin
            r = {XLEN{b[7]}};
            r[7:0] = b;
         end
         3'b100: r[7:0] = b;
         3'b001: begin
            r = {XLEN{h[15]}};
            r[15:0] = h;
         end
         3'b101: r[15:0] = h;
         3'b010: begin
            r = {XLEN{w[31]}};
            r[31:0] = w;
         end
         default: r = {XLEN{1'b0}};
      endcase
      return r;
   endfunction

   assign accept_s = in_valid && in_ready_q;

   // non-load source select
   always_comb begin
      src_data_s = alu_res;
      case (wr_src)
         2'b00:   src_data_s = alu_res;
         2'b10:   src_data_s = pc_plus4;
         2'b11:   src_data_s = imm;
         default: src_data_s = alu_res;
      endcase
   end

   // next-state and capture logic
   always_comb begin
      state_d     = state_q;
      pend_addr_d = pend_addr_q;
      pend_f3_d   = pend_f3_q;
      pend_off_d  = pend_off_q;
      cap_en_s    = 1'b0;
      cap_addr_s  = rd_addr;
      cap_data_s  = src_data_s;
      case (state_q)
         IDLE, WRITE: begin
            if (accept_s) begin
               if (wr_src == 2'b01) begin
                  if (mem_rvalid) begin
                     state_d    = WRITE;
                     cap_en_s   = 1'b1;
                     cap_data_s = ld_extend(mem_rdata, ld_funct3, ld_off);
                  end else begin
                     state_d     = WAIT_MEM;
                     pend_addr_d = rd_addr;
                     pend_f3_d   = ld_funct3;
                     pend_off_d  = ld_off;
                  end
               end else begin
                  state_d  = WRITE;
                  cap_en_s = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT_MEM: begin
            if (mem_rvalid) begin
               state_d    = WRITE;
               cap_en_s   = 1'b1;
               cap_addr_s = pend_addr_q;
               cap_data_s = ld_extend(mem_rdata, pend_f3_q, pend_off_q);
            end else begin
               state_d = WAIT_MEM;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // write port: x0 targets produce no write and leave address/data untouched
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      in_ready_d = (state_d != WAIT_MEM);
      if (cap_en_s && (cap_addr_s != {REG_AW{1'b0}})) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = cap_addr_s;
         rf_wdata_d = cap_data_s;
      end else begin
         rf_we_d = 1'b0;
      end
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= {REG_AW{1'b0}};
         rf_wdata_q  <= {XLEN{1'b0}};
         pend_addr_q <= {REG_AW{1'b0}};
         pend_f3_q   <= 3'b000;
         pend_off_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         rf_we_q     <= rf_we_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wdata_q  <= rf_wdata_d;
         pend_addr_q <= pend_addr_d;
         pend_f3_q   <= pend_f3_d;
         pend_off_q  <= pend_off_d;
      end
   end

   assign in_ready = in_ready_q;
   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

`ifdef WB_BYPASS_EN
   // rf_we_q is 0 throughout WAIT_MEM, so decode stalls on a pending load
   assign byp_valid = rf_we_q;
   assign byp_addr  = rf_waddr_q;
   assign byp_data  = rf_wdata_q;
`else
   assign byp_valid = 1'b0;
   assign byp_addr  = {REG_AW{1'b0}};
   assign byp_data  = {XLEN{1'b0}};
`endif

endmodule
